// File: rtl/mem_io_responder.sv
// Data-memory responder for the EXE stage: 240 B RAM plus memory-mapped pixel, text,
// number display, RNG and controller registers at 0xF0-0xFF.
module mem_io_responder #(
  parameter int         CHARS     = 10,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [7:0]         mem_addr,
  input  logic [7:0]         mem_wdata,
  output logic [7:0]         mem_rdata,
  input  logic [7:0]         ctrl_in,
  input  logic               pix_in,
  output logic [4:0]         pix_x,
  output logic [4:0]         pix_y,
  output logic               pix_draw,
  output logic               pix_clear,
  output logic               scr_swap,
  output logic               scr_clear,
  output logic [CHARS*5-1:0] char_disp,
  output logic               char_ovf,
  output logic [7:0]         num_value,
  output logic               num_valid,
  output logic               num_signed
);
  localparam int FW = $clog2(CHARS + 1);

  logic       acc, acc_wr, acc_rd, is_io;
  logic [3:0] io_sel;
  logic       io_wr;

  assign acc    = clk_en & mem_req;
  assign acc_wr = acc & mem_we;
  assign acc_rd = acc & ~mem_we;
  assign is_io  = (mem_addr[7:4] == 4'hF);
  assign io_sel = mem_addr[3:0];
  assign io_wr  = acc_wr & is_io;

  // RAM contents are intentionally not reset
  logic [7:0] ram [0:239];
  always_ff @(posedge clk)
    if (acc_wr && !is_io) ram[mem_addr] <= mem_wdata;

  logic [7:0] lfsr;
  logic [7:0] ctrl_s1, ctrl_s2;
  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = 8'h00;
    if (!is_io) rd_mux = ram[mem_addr];
    else begin
      case (io_sel)
        4'h4:    rd_mux = {7'b0, pix_in};
        4'hE:    rd_mux = lfsr;
        4'hF:    rd_mux = ctrl_s2;
        default: rd_mux = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)         mem_rdata <= 8'h00;
    else if (acc_rd) mem_rdata <= rd_mux;

  // Controller synchroniser runs every clk, independent of clk_en
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ctrl_s1 <= 8'h00;
      ctrl_s2 <= 8'h00;
    end else begin
      ctrl_s1 <= ctrl_in;
      ctrl_s2 <= ctrl_s1;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst)         lfsr <= LFSR_SEED;
    else if (clk_en) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Strobes reload every clk so they can never be stretched by a stalled clk_en
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pix_draw  <= 1'b0;
      pix_clear <= 1'b0;
      scr_swap  <= 1'b0;
      scr_clear <= 1'b0;
    end else begin
      pix_draw  <= io_wr && io_sel == 4'h2;
      pix_clear <= io_wr && io_sel == 4'h3;
      scr_swap  <= io_wr && io_sel == 4'h5;
      scr_clear <= io_wr && io_sel == 4'h6;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pix_x      <= 5'd0;
      pix_y      <= 5'd0;
      num_value  <= 8'h00;
      num_valid  <= 1'b0;
      num_signed <= 1'b0;
    end else if (io_wr) begin
      case (io_sel)
        4'h0: pix_x <= mem_wdata[4:0];
        4'h1: pix_y <= mem_wdata[4:0];
        4'hA: begin
          num_value <= mem_wdata;
          num_valid <= 1'b1;
        end
        4'hB: num_valid  <= 1'b0;
        4'hC: num_signed <= 1'b1;
        4'hD: num_signed <= 1'b0;
        default: ;
      endcase
    end

  logic [CHARS-1:0][4:0] stage, disp_q;
  logic [FW-1:0]         fill;
  logic                  wr_char, show_char, clr_char, full;

  assign wr_char   = io_wr && io_sel == 4'h7;
  assign show_char = io_wr && io_sel == 4'h8;
  assign clr_char  = io_wr && io_sel == 4'h9;
  assign full      = (fill == FW'(CHARS));
  assign char_disp = disp_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stage    <= '0;
      fill     <= '0;
      char_ovf <= 1'b0;
      disp_q   <= '0;
    end else begin
      if (clr_char) begin
        stage    <= '0;
        fill     <= '0;
        char_ovf <= 1'b0;
      end else if (wr_char) begin
        if (full) char_ovf <= 1'b1;
        else begin
          for (int i = 0; i < CHARS; i++)
            if (fill == FW'(i)) stage[i] <= mem_wdata[4:0];
          fill <= fill + 1'b1;
        end
      end
      if (show_char) disp_q <= stage;
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed plus randomized bench for mem_io_responder against a behavioural model.
module tb_mem_io_responder;
  localparam int CHARS = 10;

  logic clk = 1'b0, rst = 1'b1, clk_en = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [7:0] mem_addr = '0, mem_wdata = '0, mem_rdata, ctrl_in = '0;
  logic pix_in = 1'b0;
  logic [4:0] pix_x, pix_y;
  logic pix_draw, pix_clear, scr_swap, scr_clear, char_ovf, num_valid, num_signed;
  logic [CHARS*5-1:0] char_disp;
  logic [7:0] num_value;

  int tests = 0, fails = 0;

  mem_io_responder #(.CHARS(CHARS), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ctrl_in(ctrl_in), .pix_in(pix_in), .pix_x(pix_x), .pix_y(pix_y),
    .pix_draw(pix_draw), .pix_clear(pix_clear), .scr_swap(scr_swap), .scr_clear(scr_clear),
    .char_disp(char_disp), .char_ovf(char_ovf), .num_value(num_value),
    .num_valid(num_valid), .num_signed(num_signed));

  always #5 clk = ~clk;

  // behavioural model state
  logic [7:0] m_ram [0:255];
  logic [7:0] m_rdata, m_lfsr, m_numv, m_c1, m_c2;
  logic [4:0] m_px, m_py;
  logic [4:0] m_stage [0:CHARS-1];
  logic [4:0] m_disp  [0:CHARS-1];
  int         m_fill;
  logic       m_ovf, m_nvalid, m_nsigned;
  logic [3:0] m_strb;  // {scr_clear, scr_swap, pix_clear, pix_draw}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CHARS*5-1:0] pack_disp();
    logic [CHARS*5-1:0] v;
    v = '0;
    for (int i = 0; i < CHARS; i++) v[i*5 +: 5] = m_disp[i];
    return v;
  endfunction

  task automatic model_reset();
    m_rdata = 0; m_lfsr = 8'hA5; m_numv = 0; m_c1 = 0; m_c2 = 0;
    m_px = 0; m_py = 0; m_fill = 0; m_ovf = 0; m_nvalid = 0; m_nsigned = 0; m_strb = 0;
    for (int i = 0; i < CHARS; i++) begin m_stage[i] = 0; m_disp[i] = 0; end
  endtask

  task automatic check_all();
    chk("mem_rdata", mem_rdata, m_rdata);
    chk("pix_x", pix_x, m_px);
    chk("pix_y", pix_y, m_py);
    chk("strobes", {scr_clear, scr_swap, pix_clear, pix_draw}, m_strb);
    chk("char_disp", char_disp, pack_disp());
    chk("char_ovf", char_ovf, m_ovf);
    chk("num_value", num_value, m_numv);
    chk("num_valid", num_valid, m_nvalid);
    chk("num_signed", num_signed, m_nsigned);
  endtask

  // One clock: drive, step the model by the rules, then compare everything
  task automatic cyc(input bit en, input bit req, input bit we, input logic [7:0] a,
                     input logic [7:0] d);
    bit acc;
    clk_en = en; mem_req = req; mem_we = we; mem_addr = a; mem_wdata = d;
    @(posedge clk);
    acc = en && req;
    m_strb = 0;
    if (acc && !we) begin
      if (a < 8'hF0)      m_rdata = m_ram[a];
      else if (a == 8'hF4) m_rdata = {7'b0, pix_in};
      else if (a == 8'hFE) m_rdata = m_lfsr;
      else if (a == 8'hFF) m_rdata = m_c2;
      else                 m_rdata = 8'h00;
    end
    if (acc && we) begin
      if (a < 8'hF0) m_ram[a] = d;
      else case (a)
        8'hF0: m_px = d[4:0];
        8'hF1: m_py = d[4:0];
        8'hF2: m_strb[0] = 1;
        8'hF3: m_strb[1] = 1;
        8'hF5: m_strb[2] = 1;
        8'hF6: m_strb[3] = 1;
        8'hF7: if (m_fill == CHARS) m_ovf = 1;
               else begin m_stage[m_fill] = d[4:0]; m_fill++; end
        8'hF8: for (int i = 0; i < CHARS; i++) m_disp[i] = m_stage[i];
        8'hF9: begin
          m_fill = 0; m_ovf = 0;
          for (int i = 0; i < CHARS; i++) m_stage[i] = 0;
        end
        8'hFA: begin m_numv = d; m_nvalid = 1; end
        8'hFB: m_nvalid = 0;
        8'hFC: m_nsigned = 1;
        8'hFD: m_nsigned = 0;
        default: ;
      endcase
    end
    if (en) m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    m_c2 = m_c1; m_c1 = ctrl_in;
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #2;
    check_all();  // reset state
    @(posedge clk); #1;
    rst = 1'b0;

    // prefill the RAM regions the random phase reads
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, 8'(i), 8'($urandom));
    for (int i = 8'hE8; i < 8'hF0; i++) cyc(1, 1, 1, 8'(i), 8'($urandom));

    // RAM, and I/O writes never alias RAM
    cyc(1, 1, 1, 8'h10, 8'h3C);
    cyc(1, 1, 0, 8'h10, 8'h00);
    chk("ram_rd_0x10", mem_rdata, 8'h3C);
    cyc(1, 1, 1, 8'hF0, 8'h55);
    chk("pix_x_0x15", pix_x, 5'h15);
    cyc(1, 1, 0, 8'h10, 8'h00);
    chk("ram_after_io_wr", mem_rdata, 8'h3C);
    cyc(1, 1, 1, 8'hEF, 8'h9A);
    cyc(1, 1, 0, 8'hEF, 8'h00);
    chk("ram_top_0xEF", mem_rdata, 8'h9A);

    // pixel cursor and draw strobe, stalled cycle after a strobe
    cyc(1, 1, 1, 8'hF0, 8'h07);
    cyc(1, 1, 1, 8'hF1, 8'h1F);
    cyc(1, 1, 1, 8'hF2, 8'hFF);
    chk("pix_draw_hi", pix_draw, 1'b1);
    cyc(0, 1, 1, 8'hF2, 8'hFF);
    chk("pix_draw_drop", pix_draw, 1'b0);
    pix_in = 1'b1;
    cyc(1, 1, 0, 8'hF4, 8'h00);
    chk("pix_in_rd", mem_rdata, 8'h01);
    cyc(1, 1, 0, 8'hF7, 8'h00);
    chk("f7_rd_no_side", mem_rdata, 8'h00);

    // char buffer with overflow
    cyc(1, 1, 1, 8'hF9, 8'h00);
    for (int i = 1; i <= 11; i++) cyc(1, 1, 1, 8'hF7, 8'(i));
    cyc(1, 1, 1, 8'hF8, 8'h00);
    chk("char_ovf_set", char_ovf, 1'b1);
    chk("char_slot9", char_disp[45 +: 5], 5'd10);
    cyc(1, 1, 1, 8'hF9, 8'h00);
    chk("char_ovf_clr", char_ovf, 1'b0);
    chk("char_slot0_kept", char_disp[4:0], 5'd1);

    // number display
    cyc(1, 1, 1, 8'hFA, 8'h80);
    cyc(1, 1, 1, 8'hFC, 8'h00);
    chk("num_signed", {num_value, num_valid, num_signed}, {8'h80, 2'b11});
    cyc(1, 1, 1, 8'hFB, 8'h00);
    chk("num_invalid", {num_value, num_valid}, {8'h80, 1'b0});

    // mid-operation reset cancels a live strobe
    cyc(1, 1, 1, 8'hF5, 8'h00);
    chk("scr_swap_hi", scr_swap, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // RNG sequence from seed, then hold with clk_en low
    cyc(1, 1, 0, 8'hFE, 8'h00);
    chk("lfsr_0", mem_rdata, 8'hA5);
    cyc(1, 1, 0, 8'hFE, 8'h00);
    chk("lfsr_1", mem_rdata, 8'h4A);
    cyc(1, 1, 0, 8'hFE, 8'h00);
    cyc(0, 1, 0, 8'hFE, 8'h00);
    cyc(0, 1, 1, 8'hF0, 8'h1A);
    cyc(1, 1, 0, 8'hFE, 8'h00);

    // controller synchroniser after a stable input
    ctrl_in = 8'hC3;
    cyc(1, 0, 0, 8'h00, 8'h00);
    cyc(1, 0, 0, 8'h00, 8'h00);
    cyc(1, 1, 0, 8'hFF, 8'h00);
    chk("ctrl_sync", mem_rdata, 8'hC3);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [7:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5)      a = 8'hF0 | 8'($urandom_range(0, 15));
      else if (sel < 8) a = 8'($urandom_range(0, 15));
      else              a = 8'($urandom_range(8'hE8, 8'hEF));
      pix_in = 1'($urandom);
      if ($urandom_range(0, 7) == 0) ctrl_in = 8'($urandom);
      cyc($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, 1'($urandom), a,
          8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
